// File: rtl/quadrature_decoder_if.sv
// quadrature_decoder_if
//   Bundles the quadrature decoder's pin-side inputs and decoded outputs.
//   master : the source side (drives A/B and pos_clear, observes results)
//   slave  : the decoder itself
// Signals:
//   A, B       phase pair, asynchronous to clk
//   pos_clear  synchronous clear of the position count only
//   step_cw    one-cycle pulse per clockwise step
//   step_ccw   one-cycle pulse per counter-clockwise step
//   err        one-cycle pulse per illegal (both-bits-changed) transition
//   dir        last valid direction, 1 = clockwise
//   position   signed, wrapping step count (POS_W bits)
//   err_count  saturating illegal-transition count (ERR_W bits)
//   dbg_warm   warm-up counter state, 3 = decoding enabled
// Handshake: there is no valid/ready pair; every output is registered and
//   qualified only by the clock. Pulses are high for exactly one cycle.
interface quadrature_decoder_if #(
  parameter int POS_W = 16,
  parameter int ERR_W = 8
);
  logic             A;
  logic             B;
  logic             pos_clear;
  logic             step_cw;
  logic             step_ccw;
  logic             err;
  logic             dir;
  logic [POS_W-1:0] position;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       dbg_warm;

  modport master (
    output A, B, pos_clear,
    input  step_cw, step_ccw, err, dir, position, err_count, dbg_warm
  );

  modport slave (
    input  A, B, pos_clear,
    output step_cw, step_ccw, err, dir, position, err_count, dbg_warm
  );
endinterface

// File: rtl/quadrature_decoder.sv
// quadrature_decoder
//   Synchronizes an asynchronous A/B quadrature pair into clk, decodes each
//   Gray-code transition into a clockwise or counter-clockwise step, and keeps
//   a wrapping signed position, last direction and a saturating error count.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous, active-high reset
//   bus  quadrature_decoder_if.slave (A, B, pos_clear in; pulses, dir,
//        position, err_count, dbg_warm out)
// Latency: an A/B change set up before edge n is visible on the outputs
//   after edge n+2.
module quadrature_decoder #(
  parameter int POS_W = 16,
  parameter int ERR_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  quadrature_decoder_if.slave  bus
);

  // Warm-up counter: 0..2 means still settling, WARM_DONE means decoding.
  localparam logic [1:0] WARM_DONE = 2'd3;

  logic [1:0]       r_s1;
  logic [1:0]       r_s2;
  logic [1:0]       r_prev;
  logic [1:0]       r_warm;
  logic             r_step_cw;
  logic             r_step_ccw;
  logic             r_err;
  logic             r_dir;
  logic [POS_W-1:0] r_position;
  logic [ERR_W-1:0] r_err_count;

  logic w_active;
  logic w_cw;
  logic w_ccw;
  logic w_bad;

  assign w_active = (r_warm == WARM_DONE);

  // Phase is {A,B}. Clockwise order is 00 -> 10 -> 11 -> 01 -> 00; any other
  // single-bit change is counter-clockwise, and a two-bit change is illegal.
  always_comb begin
    w_cw  = 1'b0;
    w_ccw = 1'b0;
    w_bad = 1'b0;
    if (w_active && (r_prev != r_s2)) begin
      if ((r_prev ^ r_s2) == 2'b11) begin
        w_bad = 1'b1;
      end else begin
        case ({r_prev, r_s2})
          4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_cw  = 1'b1;
          default:                                w_ccw = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1        <= 2'b00;
      r_s2        <= 2'b00;
      r_prev      <= 2'b00;
      r_warm      <= 2'd0;
      r_step_cw   <= 1'b0;
      r_step_ccw  <= 1'b0;
      r_err       <= 1'b0;
      r_dir       <= 1'b1;
      r_position  <= '0;
      r_err_count <= '0;
    end else begin
      r_s1   <= {bus.A, bus.B};
      r_s2   <= r_s1;
      r_prev <= r_s2;

      // prev keeps tracking s2 during warm-up, so whatever level A/B held at
      // reset release becomes the baseline instead of a bogus transition.
      if (!w_active) begin
        r_warm <= r_warm + 2'd1;
      end

      r_step_cw  <= w_cw;
      r_step_ccw <= w_ccw;
      r_err      <= w_bad;

      if (w_cw) begin
        r_dir <= 1'b1;
      end else if (w_ccw) begin
        r_dir <= 1'b0;
      end

      // Clear wins over a same-cycle step; the step still pulses and sets dir.
      if (bus.pos_clear) begin
        r_position <= '0;
      end else if (w_cw) begin
        r_position <= r_position + POS_W'(1);
      end else if (w_ccw) begin
        r_position <= r_position - POS_W'(1);
      end

      if (w_bad && (r_err_count != {ERR_W{1'b1}})) begin
        r_err_count <= r_err_count + ERR_W'(1);
      end
    end
  end

  assign bus.step_cw   = r_step_cw;
  assign bus.step_ccw  = r_step_ccw;
  assign bus.err       = r_err;
  assign bus.dir       = r_dir;
  assign bus.position  = r_position;
  assign bus.err_count = r_err_count;
  assign bus.dbg_warm  = r_warm;

endmodule

// File: doc/quadrature_decoder.md
Name: quadrature_decoder

Overview:
- Receive-side counterpart of the team's quadrature encoder: accepts the two-phase A/B signal pair and recovers the rotation steps.
- Synchronizes A/B into the clk domain and decodes each legal Gray-code transition as one clockwise or counter-clockwise step.
- Maintains a signed position count, direction, and an illegal-transition error counter.
- Sits between the encoder output (or an external pin pair) and downstream control logic.

Parameters:
- POS_W, 16, width of the signed position counter (two's complement, wraps).
- ERR_W, 8, width of the saturating illegal-transition counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  1  quadrature phase A; asynchronous to clk.
- B  input  1  quadrature phase B; asynchronous to clk.
- pos_clear  input  1  synchronous clear of position only.
- step_cw  output  1  one-cycle pulse per clockwise step.
- step_ccw  output  1  one-cycle pulse per counter-clockwise step.
- err  output  1  one-cycle pulse per illegal transition.
- dir  output  1  last valid direction: 1 = clockwise, 0 = counter-clockwise.
- position  output  POS_W  signed step count.
- err_count  output  ERR_W  saturating illegal-transition count.

Behaviour:
- Phase state is {A,B}.
  - Clockwise sequence: 00->10->11->01->00.
  - Counter-clockwise sequence: 00->01->11->10->00.
- Synchronizer: two flops per input (s1, s2), reset to 0. Decode uses s2 and registered prev state.
- Warm-up: for the first 3 rising edges after rst deasserts, prev <= s2 and no decode occurs; all pulses stay 0. This prevents false errors when reset releases with A/B not at 00.
- Decode each cycle after warm-up, comparing prev to s2; prev <= s2 every cycle.
  - Equal: no event.
  - Clockwise transition: step_cw=1, position+1, dir<=1.
  - Counter-clockwise transition: step_ccw=1, position-1, dir<=0.
  - Both bits changed (00<->11, 10<->01): err=1, err_count+1 (saturating at all-ones), position and dir unchanged.
- Outputs are registered. Pulses are high for exactly one cycle.
- Latency: an A/B change set up before edge n produces its pulse and the updated position/dir/err_count after edge n+2 (3 edges total).
- position wraps in two's complement: max+1 -> min, min-1 -> max.
- pos_clear: position <= 0 on the next edge.
  - A step decoded in the same cycle still pulses step_cw/step_ccw and updates dir, but is not added to position.
  - pos_clear does not affect err_count, dir, or warm-up.
- At most one event per cycle. Inputs that toggle faster than 1 transition per clk cycle after synchronization appear as illegal transitions.
- Reset values: s1=s2=prev=00, warm-up restarts, step_cw=step_ccw=err=0, dir=1, position=0, err_count=0.
- rst asserted mid-operation: all state returns to reset values on that edge, regardless of A/B activity or pos_clear.

Test Plan:
- Reset, then drive A/B clockwise 00->10->11->01->00, holding each value 4 cycles -> 4 step_cw pulses, each 3 edges after its change; position=4; dir=1; err_count=0.
- From position 4, drive 6 counter-clockwise steps -> 6 step_ccw pulses; position=-2 (0xFFFE for POS_W=16); dir=0.
- Drive 00->11 in a single change -> one err pulse; err_count=1; position and dir unchanged; no step pulses.
- POS_W=4: advance to position 7, one more clockwise step -> position=-8. From -8, one counter-clockwise step -> 7.
- Assert pos_clear in the same cycle a clockwise step is decoded -> step_cw pulses, dir=1, position=0 (not 1).
- Hold A/B=11, assert rst 2 cycles then release -> no err during or after warm-up; err_count=0. Next change 11->01 -> step_cw, position=1.
